rename_regfile: RTL and testbench
=================================

Name: rename_regfile

Overview:
- Architectural register file with per-register rename tags. It is the opposite end of the ROB commit/search interface.
- Records which ROB entry will produce each register when the decoder issues an instruction.
- Resolves decoder source operands as either a value or a ROB dependency tag, querying the ROB search ports when needed.
- Retires values on ROB commit and drops all tags on pipeline clear.

Parameters:
- ROB_W, 3, ROB index width; must match the ROB's entry index width.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  pause when low; no state changes
- clear  in  1  misprediction flush from ROB
- dec_ready  in  1  decoder issues an instruction this cycle
- dec_rd  in  5  destination register of the issued instruction
- dec_rob_id  in  ROB_W  ROB entry allocated to the issued instruction
- dec_rs1, dec_rs2  in  5  source register indices
- rs1_val, rs2_val  out  32  operand value, valid when dep flag is 0
- rs1_has_dep, rs2_has_dep  out  1  operand still pending in ROB
- rs1_dep, rs2_dep  out  ROB_W  producing ROB id when dep flag is 1
- commit_valid  in  1  ROB commit strobe for this cycle
- commit_rob_id  in  ROB_W  committing entry
- commit_reg_id  in  5  committing destination register
- commit_val  in  32  committing value
- search_rob_id_1, search_rob_id_2  out  ROB_W  ROB lookup tags
- search_ready_1, search_ready_2  in  1  ROB entry has its result
- search_val_1, search_val_2  in  32  ROB entry result

Behaviour:
- State per register i: val[i] (32 bits), busy[i] (1 bit), tag[i] (ROB_W bits).
- Reset (rst_n_in low, asynchronous): all val, busy and tag cleared to 0. All outputs are combinational and follow from this state.
- Stall (rdy_in low): state holds. Combinational outputs still track their inputs.
- Commit, on a rising edge with rdy_in high and commit_valid high and commit_reg_id != 0:
  - val[commit_reg_id] <= commit_val.
  - busy[commit_reg_id] <= 0 only if tag[commit_reg_id] == commit_rob_id. A younger rename keeps busy set.
- Issue, on a rising edge with rdy_in high, dec_ready high and dec_rd != 0:
  - busy[dec_rd] <= 1 and tag[dec_rd] <= dec_rob_id.
  - Issue overrides the commit busy-clear when both target the same register. The committed value is still written.
- Clear, on a rising edge with rdy_in high and clear high:
  - All busy bits <= 0; values are kept.
  - Any same-cycle issue is discarded.
  - Any same-cycle commit value is still written.
- Operand resolution for each source s (combinational):
  - s == 0: value 0, has_dep 0.
  - !busy[s]: value val[s], has_dep 0.
  - busy[s] and search_ready for tag[s]: value is the ROB search value, has_dep 0.
  - Otherwise: has_dep 1, dep = tag[s], value 0.
  - search_rob_id_1 = tag[dec_rs1] and search_rob_id_2 = tag[dec_rs2] at all times.
- Sources are always resolved against the pre-issue mapping. An instruction with rs == rd sees the older producer, never itself.
- No ROB-width wrap handling is needed. Tag equality alone decides retirement because the ROB never reuses an id while it is in flight.

Optional Feature:
- Macro: REGFILE_COMMIT_BYPASS_EN.
- When defined: an operand whose register is busy with tag == commit_rob_id while commit_valid is high resolves to commit_val with has_dep 0 in that same cycle. This has priority over the ROB search result.
- When undefined: no bypass path; resolution relies only on search_ready and search_val.

Decomposition:
- Shared package holds:
  - ROB_W;
  - register index width 5;
  - ROB type encodings BR=2'b00, ST=2'b01, JALR=2'b10, RG=2'b11;
  - ROB status encodings IS/WR/CO.
- Natural sub-module: regfile_operand_port, the combinational per-source resolver (x0 / busy / search / bypass). Instantiated twice.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> both values 0, both has_dep 0.
- Issue rd=5, rob_id=2; next cycle read rs1=5 with search_ready_1=0 -> has_dep=1, dep=2, search_rob_id_1=2. Then raise search_ready_1 with search_val_1=0x1234 -> value 0x1234, has_dep=0.
- Issue rd=7/rob 1, then rd=7/rob 3; commit rob 1, reg 7, val 0xAA -> val[7]=0xAA, busy[7] stays 1 with tag 3.
- Same cycle: commit rob 4 / reg 9 / val 0x55 and issue rd=9 / rob 6 -> busy[9]=1, tag=6, val[9]=0x55.
- Busy on x3, x4; assert clear together with commit reg 3 / val 0x77 -> all has_dep 0, x3 reads 0x77, x4 reads its old value. A same-cycle issue to x8 leaves x8 not busy.
- Bypass build: x6 busy on tag 5; commit_valid with rob 5 / val 0xBEEF and search_ready_1=0 -> rs1_val 0xBEEF, has_dep 0. Without the macro -> has_dep 1. Also: commit to reg 0 leaves x0 reading 0.

Source files
------------

// File: rtl/rename_regfile_pkg.sv
// Shared constants and ROB encodings for the rename register file slice.
package rename_regfile_pkg;

  localparam int unsigned ROB_W = 3;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    TypeBr   = 2'b00,
    TypeSt   = 2'b01,
    TypeJalr = 2'b10,
    TypeRg   = 2'b11
  } rob_type_e;

  typedef enum logic [1:0] {
    StatIs = 2'b00,
    StatWr = 2'b01,
    StatCo = 2'b10
  } rob_status_e;

endpackage

// File: rtl/rename_regfile_operand_port.sv
// Combinational resolver for one decoder source operand: x0, ready value, ROB search or pending tag.
// REGFILE_COMMIT_BYPASS_EN adds a same-cycle forward from the commit bus ahead of the ROB search.
module rename_regfile_operand_port import rename_regfile_pkg::*; #(
  parameter int unsigned ROB_W = rename_regfile_pkg::ROB_W
) (
  input  logic [REG_W-1:0] src_idx,
  input  logic [31:0]      reg_val,
  input  logic             reg_busy,
  input  logic [ROB_W-1:0] reg_tag,
  input  logic             search_ready,
  input  logic [31:0]      search_val,
`ifdef REGFILE_COMMIT_BYPASS_EN
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [31:0]      commit_val,
`endif
  output logic [31:0]      val,
  output logic             has_dep,
  output logic [ROB_W-1:0] dep
);

  always_comb begin
    val     = '0;
    has_dep = 1'b0;
    dep     = reg_tag;
    if (src_idx == '0) begin
      val = '0;
    end else if (!reg_busy) begin
      val = reg_val;
`ifdef REGFILE_COMMIT_BYPASS_EN
    end else if (commit_valid && (commit_rob_id == reg_tag)) begin
      val = commit_val;
`endif
    end else if (search_ready) begin
      val = search_val;
    end else begin
      has_dep = 1'b1;
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register ROB rename tags; commits retire, clear drops tags.
// Optional macro REGFILE_COMMIT_BYPASS_EN forwards the commit bus straight into operand resolution.
module rename_regfile import rename_regfile_pkg::*; #(
  parameter int unsigned ROB_W = rename_regfile_pkg::ROB_W,
  parameter int unsigned NREG  = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             dec_ready,
  input  logic [REG_W-1:0] dec_rd,
  input  logic [ROB_W-1:0] dec_rob_id,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  output logic [31:0]      rs1_val,
  output logic [31:0]      rs2_val,
  output logic             rs1_has_dep,
  output logic             rs2_has_dep,
  output logic [ROB_W-1:0] rs1_dep,
  output logic [ROB_W-1:0] rs2_dep,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [REG_W-1:0] commit_reg_id,
  input  logic [31:0]      commit_val,
  output logic [ROB_W-1:0] search_rob_id_1,
  output logic [ROB_W-1:0] search_rob_id_2,
  input  logic             search_ready_1,
  input  logic             search_ready_2,
  input  logic [31:0]      search_val_1,
  input  logic [31:0]      search_val_2
);

  logic [31:0]      val_q [NREG];
  logic [31:0]      val_d [NREG];
  logic [ROB_W-1:0] tag_q [NREG];
  logic [ROB_W-1:0] tag_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;

  // Issue is applied after commit so a same-register rename keeps busy set.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (rdy_in) begin
      if (commit_valid && (commit_reg_id != '0)) begin
        val_d[commit_reg_id] = commit_val;
        if (tag_q[commit_reg_id] == commit_rob_id) begin
          busy_d[commit_reg_id] = 1'b0;
        end
      end
      if (clear) begin
        busy_d = '0;
      end else if (dec_ready && (dec_rd != '0)) begin
        busy_d[dec_rd] = 1'b1;
        tag_d[dec_rd]  = dec_rob_id;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  assign search_rob_id_1 = tag_q[dec_rs1];
  assign search_rob_id_2 = tag_q[dec_rs2];

  rename_regfile_operand_port #(
    .ROB_W (ROB_W)
  ) u_port_rs1 (
    .src_idx       (dec_rs1),
    .reg_val       (val_q[dec_rs1]),
    .reg_busy      (busy_q[dec_rs1]),
    .reg_tag       (tag_q[dec_rs1]),
    .search_ready  (search_ready_1),
    .search_val    (search_val_1),
`ifdef REGFILE_COMMIT_BYPASS_EN
    .commit_valid  (commit_valid),
    .commit_rob_id (commit_rob_id),
    .commit_val    (commit_val),
`endif
    .val           (rs1_val),
    .has_dep       (rs1_has_dep),
    .dep           (rs1_dep)
  );

  rename_regfile_operand_port #(
    .ROB_W (ROB_W)
  ) u_port_rs2 (
    .src_idx       (dec_rs2),
    .reg_val       (val_q[dec_rs2]),
    .reg_busy      (busy_q[dec_rs2]),
    .reg_tag       (tag_q[dec_rs2]),
    .search_ready  (search_ready_2),
    .search_val    (search_val_2),
`ifdef REGFILE_COMMIT_BYPASS_EN
    .commit_valid  (commit_valid),
    .commit_rob_id (commit_rob_id),
    .commit_val    (commit_val),
`endif
    .val           (rs2_val),
    .has_dep       (rs2_has_dep),
    .dep           (rs2_dep)
  );

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: directed scenarios with literal expectations, then random traffic vs a model.
module tb_rename_regfile;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in, clear, dec_ready, commit_valid;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2, commit_reg_id;
  logic [2:0]  dec_rob_id, commit_rob_id;
  logic [31:0] rs1_val, rs2_val, commit_val, search_val_1, search_val_2;
  logic        rs1_has_dep, rs2_has_dep, search_ready_1, search_ready_2;
  logic [2:0]  rs1_dep, rs2_dep, search_rob_id_1, search_rob_id_2;

  int checks = 0;
  int failures = 0;

  // Reference state: what each architectural register holds and who will produce it.
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [2:0]  m_tag  [32];

  rename_regfile dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rdy_in          (rdy_in),
    .clear           (clear),
    .dec_ready       (dec_ready),
    .dec_rd          (dec_rd),
    .dec_rob_id      (dec_rob_id),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .rs1_val         (rs1_val),
    .rs2_val         (rs2_val),
    .rs1_has_dep     (rs1_has_dep),
    .rs2_has_dep     (rs2_has_dep),
    .rs1_dep         (rs1_dep),
    .rs2_dep         (rs2_dep),
    .commit_valid    (commit_valid),
    .commit_rob_id   (commit_rob_id),
    .commit_reg_id   (commit_reg_id),
    .commit_val      (commit_val),
    .search_rob_id_1 (search_rob_id_1),
    .search_rob_id_2 (search_rob_id_2),
    .search_ready_1  (search_ready_1),
    .search_ready_2  (search_ready_2),
    .search_val_1    (search_val_1),
    .search_val_2    (search_val_2)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  task automatic resolve(input logic [4:0] s, input logic sr, input logic [31:0] sv,
                         output logic [31:0] v, output logic hd, output logic [2:0] d);
    v  = '0;
    hd = 1'b0;
    d  = m_tag[s];
    if (s == 0)              v = '0;
    else if (!m_busy[s])     v = m_val[s];
`ifdef REGFILE_COMMIT_BYPASS_EN
    else if (commit_valid && commit_rob_id == m_tag[s]) v = commit_val;
`endif
    else if (sr)             v = sv;
    else                     hd = 1'b1;
  endtask

  task automatic check_all();
    logic [31:0] v;
    logic        hd;
    logic [2:0]  d;
    resolve(dec_rs1, search_ready_1, search_val_1, v, hd, d);
    chk("rs1_has_dep", {31'b0, rs1_has_dep}, {31'b0, hd});
    chk("rs1_val", rs1_val, v);
    if (hd) chk("rs1_dep", {29'b0, rs1_dep}, {29'b0, d});
    chk("search_rob_id_1", {29'b0, search_rob_id_1}, {29'b0, m_tag[dec_rs1]});
    resolve(dec_rs2, search_ready_2, search_val_2, v, hd, d);
    chk("rs2_has_dep", {31'b0, rs2_has_dep}, {31'b0, hd});
    chk("rs2_val", rs2_val, v);
    if (hd) chk("rs2_dep", {29'b0, rs2_dep}, {29'b0, d});
    chk("search_rob_id_2", {29'b0, search_rob_id_2}, {29'b0, m_tag[dec_rs2]});
  endtask

  task automatic model_update();
    if (!rdy_in) return;
    if (commit_valid && commit_reg_id != 0) begin
      m_val[commit_reg_id] = commit_val;
      if (m_tag[commit_reg_id] == commit_rob_id) m_busy[commit_reg_id] = 1'b0;
    end
    if (clear) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else if (dec_ready && dec_rd != 0) begin
      m_busy[dec_rd] = 1'b1;
      m_tag[dec_rd]  = dec_rob_id;
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear = 1'b0; dec_ready = 1'b0; dec_rd = '0; dec_rob_id = '0;
    dec_rs1 = '0; dec_rs2 = '0; commit_valid = 1'b0; commit_rob_id = '0;
    commit_reg_id = '0; commit_val = '0; search_ready_1 = 1'b0; search_ready_2 = 1'b0;
    search_val_1 = '0; search_val_2 = '0;
  endtask

  // Inputs are driven just after a falling edge; compare, advance the model, cross one rising edge.
  task automatic step();
    #1;
    check_all();
    model_update();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    rst_n_in = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk_in);

    // Reset state
    dec_rs1 = 5'd5; dec_rs2 = 5'd0;
    #1;
    chk("reset rs1_val", rs1_val, 32'h0);
    chk("reset rs1_has_dep", {31'b0, rs1_has_dep}, 32'h0);
    chk("reset rs2_val", rs2_val, 32'h0);
    chk("reset rs2_has_dep", {31'b0, rs2_has_dep}, 32'h0);
    rst_n_in = 1'b1;
    step();

    // Rename x5 to rob 2, then resolve through the search port
    idle(); dec_ready = 1'b1; dec_rd = 5'd5; dec_rob_id = 3'd2; step();
    idle(); dec_rs1 = 5'd5;
    #1;
    chk("x5 pending has_dep", {31'b0, rs1_has_dep}, 32'h1);
    chk("x5 pending dep", {29'b0, rs1_dep}, 32'h2);
    chk("x5 search id", {29'b0, search_rob_id_1}, 32'h2);
    search_ready_1 = 1'b1; search_val_1 = 32'h1234;
    #1;
    chk("x5 search val", rs1_val, 32'h1234);
    chk("x5 search has_dep", {31'b0, rs1_has_dep}, 32'h0);
    step();

    // Older commit must not retire a younger rename
    idle(); dec_ready = 1'b1; dec_rd = 5'd7; dec_rob_id = 3'd1; step();
    idle(); dec_ready = 1'b1; dec_rd = 5'd7; dec_rob_id = 3'd3; step();
    idle(); commit_valid = 1'b1; commit_rob_id = 3'd1; commit_reg_id = 5'd7;
    commit_val = 32'hAA; step();
    idle(); dec_rs1 = 5'd7;
    #1;
    chk("x7 still busy", {31'b0, rs1_has_dep}, 32'h1);
    chk("x7 younger tag", {29'b0, rs1_dep}, 32'h3);
    step();

    // Same-cycle commit and issue on x9
    idle(); commit_valid = 1'b1; commit_rob_id = 3'd4; commit_reg_id = 5'd9;
    commit_val = 32'h55; dec_ready = 1'b1; dec_rd = 5'd9; dec_rob_id = 3'd6; step();
    idle(); dec_rs1 = 5'd9;
    #1;
    chk("x9 busy after issue", {31'b0, rs1_has_dep}, 32'h1);
    chk("x9 tag", {29'b0, rs1_dep}, 32'h6);
    step();

    // Clear with concurrent commit and discarded issue
    idle(); commit_valid = 1'b1; commit_rob_id = 3'd7; commit_reg_id = 5'd4;
    commit_val = 32'h44; step();
    idle(); dec_ready = 1'b1; dec_rd = 5'd3; dec_rob_id = 3'd1; step();
    idle(); dec_ready = 1'b1; dec_rd = 5'd4; dec_rob_id = 3'd2; step();
    idle(); clear = 1'b1; commit_valid = 1'b1; commit_rob_id = 3'd5; commit_reg_id = 5'd3;
    commit_val = 32'h77; dec_ready = 1'b1; dec_rd = 5'd8; dec_rob_id = 3'd4; step();
    idle(); dec_rs1 = 5'd3; dec_rs2 = 5'd4;
    #1;
    chk("x3 after clear", rs1_val, 32'h77);
    chk("x3 has_dep", {31'b0, rs1_has_dep}, 32'h0);
    chk("x4 after clear", rs2_val, 32'h44);
    chk("x4 has_dep", {31'b0, rs2_has_dep}, 32'h0);
    dec_rs1 = 5'd8; dec_rs2 = 5'd7;
    #1;
    chk("x8 not busy", {31'b0, rs1_has_dep}, 32'h0);
    chk("x7 committed val", rs2_val, 32'hAA);
    dec_rs1 = 5'd9;
    #1;
    chk("x9 committed val", rs1_val, 32'h55);
    step();

    // Commit-bus bypass (or its absence)
    idle(); dec_ready = 1'b1; dec_rd = 5'd6; dec_rob_id = 3'd5; step();
    idle(); commit_valid = 1'b1; commit_rob_id = 3'd5; commit_reg_id = 5'd6;
    commit_val = 32'hBEEF; dec_rs1 = 5'd6;
    #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
    chk("bypass val", rs1_val, 32'hBEEF);
    chk("bypass has_dep", {31'b0, rs1_has_dep}, 32'h0);
`else
    chk("no bypass has_dep", {31'b0, rs1_has_dep}, 32'h1);
    chk("no bypass dep", {29'b0, rs1_dep}, 32'h5);
`endif
    step();

    // Writes to x0 are ignored
    idle(); commit_valid = 1'b1; commit_reg_id = 5'd0; commit_val = 32'hDEAD;
    dec_ready = 1'b1; dec_rd = 5'd0; dec_rob_id = 3'd3; step();
    idle(); dec_rs1 = 5'd0;
    #1;
    chk("x0 reads zero", rs1_val, 32'h0);
    chk("x0 has_dep", {31'b0, rs1_has_dep}, 32'h0);
    step();

    // Stall holds state
    idle(); rdy_in = 1'b0; dec_ready = 1'b1; dec_rd = 5'd10; dec_rob_id = 3'd3;
    commit_valid = 1'b1; commit_reg_id = 5'd11; commit_val = 32'h99; step();
    idle(); dec_rs1 = 5'd10; dec_rs2 = 5'd11;
    #1;
    chk("stall no issue", {31'b0, rs1_has_dep}, 32'h0);
    chk("stall no commit", rs2_val, 32'h0);
    step();

    // Asynchronous reset mid-run
    rst_n_in = 1'b0;
    model_reset();
    idle(); dec_rs1 = 5'd3; dec_rs2 = 5'd7;
    #1;
    chk("async reset x3", rs1_val, 32'h0);
    chk("async reset x7", rs2_val, 32'h0);
    rst_n_in = 1'b1;
    step();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rdy_in         = ($urandom_range(0, 9) != 0);
      clear          = ($urandom_range(0, 19) == 0);
      dec_ready      = $urandom_range(0, 1) == 1;
      dec_rd         = 5'($urandom_range(0, 7));
      dec_rob_id     = 3'($urandom);
      dec_rs1        = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      dec_rs2        = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      commit_valid   = ($urandom_range(0, 9) < 4);
      commit_reg_id  = 5'($urandom_range(0, 7));
      commit_rob_id  = $urandom_range(0, 1) ? m_tag[commit_reg_id] : 3'($urandom);
      commit_val     = $urandom;
      search_ready_1 = $urandom_range(0, 1) == 1;
      search_ready_2 = $urandom_range(0, 1) == 1;
      search_val_1   = $urandom;
      search_val_2   = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
